reflet_dma: RTL and testbench

Memory-mapped block-copy engine for the reflet system bus. Two bus roles. As a responder it exposes four configuration registers to the CPU, using the same enable/addr/write_en/data_in/data_out convention as the other reflet peripherals. As an initiator it requests the bus from the system arbiter and copies `len` words from `src` to `dst` using the reflet one-cycle-read-latency protocol, then raises a level interrupt intended for `reflet_exti`.

---
 rtl/reflet_dma.sv | 133 +++++++++++++
 tb/tb_reflet_dma.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_dma.sv
// reflet_dma: block-copy engine with CPU-visible config registers and a bus initiator.
// One word moves per RD/CAP/WR triple; losing the grant rewinds the current word to RD.
module reflet_dma #(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16,
  parameter int base_addr      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  output logic                      bus_req,
  input  logic                      bus_grant,
  output logic [wordsize-1:0]       m_addr,
  output logic                      m_write_en,
  output logic [wordsize-1:0]       m_data_out,
  input  logic [wordsize-1:0]       m_data_in,
  output logic                      interrupt
);
  // state | meaning
  // IDLE  | no transfer, initiator outputs 0
  // REQ   | bus requested, waiting for the first grant
  // RD    | source address presented
  // CAP   | source data valid, captured into buffer on the edge
  // WR    | buffer driven to destination, pointers advance on the edge
  typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR} state_t;
  state_t state, state_nxt;

  localparam logic [base_addr_size-1:0] base = base_addr_size'(base_addr);

  logic [base_addr_size-1:0] offset;
  logic                      hit, wr_hit, rd_hit, busy, start, step;
  logic [wordsize-1:0]       src, dst, len, buffer, ctrl_val;
  logic                      done, ie;

  assign offset    = addr - base;
  assign hit       = enable && (offset < base_addr_size'(4));
  assign wr_hit    = hit && write_en;
  assign rd_hit    = hit && !write_en;
  assign busy      = (state != IDLE);
  assign start     = wr_hit && (offset == '0) && data_in[0] && !busy;
  assign step      = (state == WR) && bus_grant;
  assign ctrl_val  = wordsize'({ie, done, busy, 1'b0});
  assign interrupt = done & ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len != '0) state_nxt = REQ;
      REQ:     if (bus_grant) state_nxt = RD;
      RD:      state_nxt = bus_grant ? CAP : RD;
      CAP:     state_nxt = bus_grant ? WR : RD;
      WR: begin
        if (bus_grant && len == wordsize'(1)) state_nxt = IDLE;
        else                                  state_nxt = RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_req    = 1'b0;
    m_addr     = '0;
    m_write_en = 1'b0;
    m_data_out = '0;
    case (state)
      REQ: bus_req = 1'b1;
      RD, CAP: begin
        bus_req = 1'b1;
        if (bus_grant) m_addr = src;
      end
      WR: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          m_addr     = dst;
          m_write_en = 1'b1;
          m_data_out = buffer;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      done   <= 1'b0;
      ie     <= 1'b0;
      buffer <= '0;
    end else begin
      if (wr_hit && !busy) begin
        if (offset == base_addr_size'(1)) src <= data_in;
        if (offset == base_addr_size'(2)) dst <= data_in;
        if (offset == base_addr_size'(3)) len <= data_in;
      end
      if (wr_hit && offset == '0) begin
        ie <= data_in[3];
        if (!data_in[2]) done <= 1'b0;
      end
      if (start) done <= (len == '0);
      if (state == CAP && bus_grant) buffer <= m_data_in;
      // completion must win over a CPU clear landing on the same edge
      if (step) begin
        src <= src + wordsize'(1);
        dst <= dst + wordsize'(1);
        len <= len - wordsize'(1);
        if (len == wordsize'(1)) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       data_out <= '0;
    else if (rd_hit) begin
      case (offset[1:0])
        2'd0:    data_out <= ctrl_val;
        2'd1:    data_out <= src;
        2'd2:    data_out <= dst;
        default: data_out <= len;
      endcase
    end else         data_out <= '0;
  end
endmodule

// File: tb/tb_reflet_dma.sv
// Directed bench for reflet_dma: a 16-bit instance at base 0 and an 8-bit instance at base 4
// share the responder bus; each has its own 1-cycle-latency memory model.
module tb_reflet_dma;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable, write_en;
  logic [15:0] addr, data_in;

  logic [15:0] data_out, m_addr, m_data_out, m_data_in;
  logic        bus_req, bus_grant, m_write_en, interrupt;
  logic [7:0]  data_out8, m_addr8, m_data_out8, m_data_in8;
  logic        bus_req8, bus_grant8, m_write_en8, interrupt8;

  logic        grant_en;
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem  [0:255];
  logic [7:0]  mem8 [0:255];

  int checks = 0, failures = 0;
  int wr_pulses = 0, we_double = 0, dout_leak = 0, req_cycles = 0;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  assign bus_grant  = bus_req & grant_en;
  assign bus_grant8 = bus_req8;

  reflet_dma #(.wordsize(16), .base_addr_size(16), .base_addr(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .bus_req(bus_req), .bus_grant(bus_grant),
    .m_addr(m_addr), .m_write_en(m_write_en), .m_data_out(m_data_out),
    .m_data_in(m_data_in), .interrupt(interrupt));

  reflet_dma #(.wordsize(8), .base_addr_size(16), .base_addr(4)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in[7:0]), .data_out(data_out8), .bus_req(bus_req8), .bus_grant(bus_grant8),
    .m_addr(m_addr8), .m_write_en(m_write_en8), .m_data_out(m_data_out8),
    .m_data_in(m_data_in8), .interrupt(interrupt8));

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr]  <= pl_data;
      mem8[pl_addr] <= pl_data[7:0];
    end else begin
      if (m_write_en)  mem[m_addr[7:0]] <= m_data_out;
      if (m_write_en8) mem8[m_addr8]    <= m_data_out8;
    end
    m_data_in  <= mem[m_addr[7:0]];
    m_data_in8 <= mem8[m_addr8];
  end

  always @(negedge clk) begin
    if (m_write_en) wr_pulses++;
    if (m_write_en && prev_we) we_double++;
    if (!m_write_en && m_data_out != 16'h0) dout_leak++;
    if (bus_req) req_cycles++;
    prev_we = m_write_en;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b0; addr = a;
    @(negedge clk);
    enable = 1'b0;
    d = {16'h0, data_out | {8'h0, data_out8}};
  endtask

  task automatic mem_load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus_req || bus_req8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'h0, bus_req | bus_req8}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int n, snap;

    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    grant_en = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge clk);
    check_val("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check_val("rst_irq", {31'h0, interrupt}, 32'h0);
    check_val("rst_data_out", {16'h0, data_out}, 32'h0);
    reset = 1'b0;
    reg_read(16'h0, rd); check_val("rst_ctrl", rd, 32'h0);
    reg_read(16'h3, rd); check_val("rst_len", rd, 32'h0);

    mem_load(8'h10, 16'h11); mem_load(8'h11, 16'h22); mem_load(8'h12, 16'h33);
    mem_load(8'h20, 16'hA1); mem_load(8'h21, 16'hA2); mem_load(8'h22, 16'hA3);
    mem_load(8'h60, 16'h61); mem_load(8'h61, 16'h62); mem_load(8'h62, 16'h63);
    mem_load(8'hFF, 16'h5A); mem_load(8'h00, 16'h5B); mem_load(8'h01, 16'h5C);

    // basic copy
    reg_write(16'h1, 16'h10); reg_write(16'h2, 16'h40); reg_write(16'h3, 16'h3);
    snap = wr_pulses;
    reg_write(16'h0, 16'h9);
    check_val("start_req", {31'h0, bus_req}, 32'h1);
    n = 0;
    while (m_addr != 16'h10 && n < 10) begin @(negedge clk); n++; end
    check_val("grant_to_rd", n, 32'd1);
    n = 0;
    while (!interrupt && n < 20) begin @(negedge clk); n++; end
    check_val("irq_latency", n, 32'd9);
    wait_idle("basic_idle");
    check_val("basic_m40", {16'h0, mem[8'h40]}, 32'h11);
    check_val("basic_m41", {16'h0, mem[8'h41]}, 32'h22);
    check_val("basic_m42", {16'h0, mem[8'h42]}, 32'h33);
    check_val("basic_pulses", wr_pulses - snap, 32'd3);
    reg_read(16'h1, rd); check_val("basic_src", rd, 32'h13);
    reg_read(16'h2, rd); check_val("basic_dst", rd, 32'h43);
    reg_read(16'h3, rd); check_val("basic_len", rd, 32'h0);
    reg_read(16'h0, rd); check_val("basic_ctrl", rd, 32'hC);

    // LEN = 0
    snap = req_cycles;
    reg_write(16'h0, 16'h1);
    check_val("len0_no_req", {31'h0, bus_req}, 32'h0);
    reg_read(16'h0, rd); check_val("len0_ctrl", rd, 32'h4);
    check_val("len0_irq_off", {31'h0, interrupt}, 32'h0);
    repeat (3) @(negedge clk);
    check_val("len0_req_cycles", req_cycles - snap, 32'd0);
    reg_write(16'h0, 16'hC);
    check_val("len0_irq_on", {31'h0, interrupt}, 32'h1);

    // grant loss during CAP of word 2
    reg_write(16'h1, 16'h20); reg_write(16'h2, 16'h50); reg_write(16'h3, 16'h3);
    snap = wr_pulses;
    reg_write(16'h0, 16'h9);
    check_val("gl_done_cleared", {31'h0, interrupt}, 32'h0);
    n = 0;
    while (m_addr != 16'h21 && n < 20) begin @(negedge clk); n++; end
    check_val("gl_w2_rd", {16'h0, m_addr}, 32'h21);
    @(negedge clk);
    grant_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check_val("gl_drop_outs", {15'h0, m_write_en, m_addr | m_data_out}, 32'h0);
      check_val("gl_drop_req", {31'h0, bus_req}, 32'h1);
    end
    @(negedge clk);
    grant_en = 1'b1;
    #1;
    check_val("gl_restart_rd", {15'h0, m_write_en, m_addr}, 32'h21);
    wait_idle("gl_idle");
    check_val("gl_m50", {16'h0, mem[8'h50]}, 32'hA1);
    check_val("gl_m51", {16'h0, mem[8'h51]}, 32'hA2);
    check_val("gl_m52", {16'h0, mem[8'h52]}, 32'hA3);
    check_val("gl_pulses", wr_pulses - snap, 32'd3);
    reg_read(16'h1, rd); check_val("gl_src", rd, 32'h23);

    // wrap-around on the 8-bit instance
    reg_write(16'h5, 16'hFF); reg_write(16'h6, 16'hFE); reg_write(16'h7, 16'h3);
    reg_write(16'h4, 16'h9);
    wait_idle("wrap_idle");
    check_val("wrap_mFE", {24'h0, mem8[8'hFE]}, 32'h5A);
    check_val("wrap_mFF", {24'h0, mem8[8'hFF]}, 32'h5B);
    check_val("wrap_m00", {24'h0, mem8[8'h00]}, 32'h5C);
    reg_read(16'h5, rd); check_val("wrap_src", rd, 32'h02);
    reg_read(16'h6, rd); check_val("wrap_dst", rd, 32'h01);
    reg_read(16'h4, rd); check_val("wrap_ctrl", rd, 32'hC);
    check_val("wrap_irq", {31'h0, interrupt8}, 32'h1);

    // busy protection
    reg_write(16'h1, 16'h60); reg_write(16'h2, 16'h70); reg_write(16'h3, 16'h3);
    snap = wr_pulses;
    reg_write(16'h0, 16'h9);
    repeat (2) @(negedge clk);
    reg_write(16'h1, 16'h77);
    reg_write(16'h0, 16'h9);
    reg_read(16'h1, rd); check_val("busy_live_src", rd, 32'h62);
    wait_idle("busy_idle");
    reg_read(16'h1, rd); check_val("busy_src", rd, 32'h63);
    check_val("busy_m70", {16'h0, mem[8'h70]}, 32'h61);
    check_val("busy_m72", {16'h0, mem[8'h72]}, 32'h63);
    check_val("busy_pulses", wr_pulses - snap, 32'd3);
    check_val("busy_irq", {31'h0, interrupt}, 32'h1);
    reg_write(16'h0, 16'h8);
    check_val("busy_irq_clr", {31'h0, interrupt}, 32'h0);
    reg_read(16'h0, rd); check_val("busy_ctrl", rd, 32'h8);

    // reset mid-transfer
    reg_write(16'h1, 16'h10); reg_write(16'h2, 16'h80); reg_write(16'h3, 16'h3);
    reg_write(16'h0, 16'h9);
    n = 0;
    while (!m_write_en && n < 20) begin @(negedge clk); n++; end
    check_val("mid_in_wr", {31'h0, m_write_en}, 32'h1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_outs", {29'h0, bus_req, m_write_en, interrupt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    reg_read(16'h0, rd); check_val("mid_ctrl", rd, 32'h0);
    reg_read(16'h1, rd); check_val("mid_src", rd, 32'h0);
    reg_read(16'h2, rd); check_val("mid_dst", rd, 32'h0);
    reg_read(16'h3, rd); check_val("mid_len", rd, 32'h0);
    reg_write(16'h1, 16'h10); reg_write(16'h2, 16'h90); reg_write(16'h3, 16'h2);
    reg_write(16'h0, 16'h9);
    wait_idle("post_idle");
    check_val("post_m90", {16'h0, mem[8'h90]}, 32'h11);
    check_val("post_m91", {16'h0, mem[8'h91]}, 32'h22);
    check_val("post_irq", {31'h0, interrupt}, 32'h1);

    check_val("we_single_cycle", we_double, 32'd0);
    check_val("dout_zero_idle", dout_leak, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
